// File: rtl/signed_mul_pkg.sv
// Shared types and sizing for the signed-magnitude multiplier scheduler.
package signed_mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SIGN,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int PROD_W    = 2*DEF_WIDTH + 1;

   // Iteration counter must hold the value WIDTH itself.
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Two-way round-robin arbiter; last_grant advances only when en is asserted.
module mul_rr_arbiter (
   input  logic clk,
   input  logic Reset,
   input  logic req0,
   input  logic req1,
   input  logic en,
   output logic gnt_any,
   output logic gnt_id
);

   logic last_grant;

   always_comb begin
      gnt_any = req0 | req1;
      gnt_id  = (req0 & req1) ? ~last_grant : req1;
   end

   // Resetting to 1 lets requester 0 win the first tie.
   always_ff @(posedge clk) begin
      if (!Reset)
         last_grant <= 1'b1;
      else if (en && gnt_any)
         last_grant <= gnt_id;
   end

endmodule

// File: rtl/signed_mul_scheduler.sv
// Shared shift-add signed-magnitude multiplier with round-robin access for two requesters.
// Define SIGNED_MUL_EARLY_TERM_EN to leave CALC once the remaining multiplier bits are zero.
module signed_mul_scheduler
   import signed_mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 req0,
   input  logic [WIDTH-1:0]     in0A,
   input  logic [WIDTH-1:0]     in0B,
   input  logic                 in0S0,
   input  logic                 in0S1,
   output logic                 ack0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     in1A,
   input  logic [WIDTH-1:0]     in1B,
   input  logic                 in1S0,
   input  logic                 in1S1,
   output logic                 ack1,
   output logic [2*WIDTH:0]     Product,
   output logic                 result_valid,
   output logic                 result_id,
   output logic                 busy
);

   localparam int AW = 2*WIDTH;
   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] mcand, mplier;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    count;
   logic             neg, id;
   logic             gnt_any, gnt_id, arb_en, calc_last;

   mul_rr_arbiter u_arb (
      .clk     (clk),
      .Reset   (Reset),
      .req0    (req0),
      .req1    (req1),
      .en      (arb_en),
      .gnt_any (gnt_any),
      .gnt_id  (gnt_id)
   );

   always_ff @(posedge clk) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      arb_en   = 1'b0;
      busy     = (state != IDLE);
`ifdef SIGNED_MUL_EARLY_TERM_EN
      calc_last = ((mplier >> 1) == '0);
`else
      calc_last = (count == CW'(WIDTH - 1));
`endif
      case (state)
         IDLE: begin
            if (gnt_any) begin
               arb_en   = 1'b1;
               state_nx = CALC;
            end
         end
         CALC:    if (calc_last) state_nx = SIGN;
         SIGN:    state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         result_valid <= 1'b0;
         result_id    <= 1'b0;
         Product      <= '0;
         mcand        <= '0;
         mplier       <= '0;
         acc          <= '0;
         count        <= '0;
         neg          <= 1'b0;
         id           <= 1'b0;
      end else begin
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_en) begin
                  id    <= gnt_id;
                  acc   <= '0;
                  count <= '0;
                  ack0  <= ~gnt_id;
                  ack1  <= gnt_id;
                  if (gnt_id) begin
                     mcand  <= in1A;
                     mplier <= in1B;
                     neg    <= in1S0 ^ in1S1;
                  end else begin
                     mcand  <= in0A;
                     mplier <= in0B;
                     neg    <= in0S0 ^ in0S1;
                  end
               end
            end
            CALC: begin
               if (mplier[0])
                  acc <= acc + (AW'(mcand) << count);
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
            end
            SIGN: begin
               // Negating a zero magnitude wraps back to zero, so no negative zero.
               Product      <= neg ? (~{1'b0, acc} + 1'b1) : {1'b0, acc};
               result_id    <= id;
               result_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_mul_scheduler.sv
// Scoreboard bench for signed_mul_scheduler; honours SIGNED_MUL_EARLY_TERM_EN for expected latency.
module tb_signed_mul_scheduler;
   import signed_mul_pkg::*;

   localparam int W  = DEF_WIDTH;
   localparam int PW = PROD_W;

   logic          clk = 1'b0;
   logic          Reset;
   logic          req0, req1;
   logic [W-1:0]  in0A, in0B, in1A, in1B;
   logic          in0S0, in0S1, in1S0, in1S1;
   logic          ack0, ack1;
   logic [PW-1:0] Product;
   logic          result_valid, result_id, busy;

   always #5 clk = ~clk;

   signed_mul_scheduler #(.WIDTH(W)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .req0         (req0),
      .in0A         (in0A),
      .in0B         (in0B),
      .in0S0        (in0S0),
      .in0S1        (in0S1),
      .ack0         (ack0),
      .req1         (req1),
      .in1A         (in1A),
      .in1B         (in1B),
      .in1S0        (in1S0),
      .in1S1        (in1S1),
      .ack1         (ack1),
      .Product      (Product),
      .result_valid (result_valid),
      .result_id    (result_id),
      .busy         (busy)
   );

   typedef struct {
      logic [PW-1:0] p;
      logic          id;
      int            due;
   } exp_t;

   exp_t          q[$];
   int            pass_cnt = 0;
   int            total    = 0;
   int            cyc      = 0;
   int            free_at  = 0;
   int            busy_lo  = 0;
   int            busy_hi  = -1;
   logic          lg       = 1'b1;
   logic [PW-1:0] last_prod = '0;
   logic          drain    = 1'b0;
   logic          fin      = 1'b0;

   // Inputs as the DUT saw them at the rising edge.
   logic          s_rst, s_req0, s_req1, s_n0, s_n1;
   logic [W-1:0]  s_a0, s_b0, s_a1, s_b1;

   always @(posedge clk) begin
      s_rst  <= Reset;
      s_req0 <= req0;
      s_req1 <= req1;
      s_a0   <= in0A;
      s_b0   <= in0B;
      s_n0   <= in0S0 ^ in0S1;
      s_a1   <= in1A;
      s_b1   <= in1B;
      s_n1   <= in1S0 ^ in1S1;
   end

   function automatic logic [PW-1:0] ref_prod(input int a, input int b, input logic n);
      int p;
      p = a * b;
      if (n) p = -p;
      return PW'(p);
   endfunction

   function automatic int calc_len(input int b);
`ifdef SIGNED_MUL_EARLY_TERM_EN
      if (b == 0) return 1;
      return $clog2(b + 1);
`else
      return W + 0*b;
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model step for the edge just passed, then monitor checks on DUT outputs.
   always @(negedge clk) begin
      exp_t e;
      logic win, ev, e_ack0, e_ack1;
      int   k;
      cyc++;
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      if (!s_rst) begin
         q.delete();
         lg        = 1'b1;
         free_at   = cyc + 1;
         busy_hi   = -1;
         last_prod = '0;
         chk("rst_result_id", result_id, 0);
      end else if (cyc >= free_at && (s_req0 || s_req1)) begin
         win   = (s_req0 && s_req1) ? ~lg : s_req1;
         lg    = win;
         e.id  = win;
         e.p   = win ? ref_prod(s_a1, s_b1, s_n1) : ref_prod(s_a0, s_b0, s_n0);
         k     = calc_len(win ? s_b1 : s_b0);
         e.due = cyc + k + 1;
         q.push_back(e);
         free_at = cyc + k + 3;
         busy_lo = cyc;
         busy_hi = cyc + k + 1;
         if (win) e_ack1 = 1'b1;
         else     e_ack0 = 1'b1;
      end

      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("result_valid", result_valid, ev);
      if (ev) begin
         e = q.pop_front();
         if (result_valid) begin
            chk("product", Product, e.p);
            chk("result_id", result_id, e.id);
         end
         last_prod = e.p;
      end else begin
         chk("product_hold", Product, last_prod);
      end
      if (drain && !fin) begin
         chk("queue_empty", q.size(), 0);
         fin = 1'b1;
      end
   end

   task automatic drive0(input logic [W-1:0] a, input logic [W-1:0] b, input logic s0, input logic s1);
      in0A = a; in0B = b; in0S0 = s0; in0S1 = s1; req0 = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ack0) break;
      end
      req0 = 1'b0;
   endtask

   task automatic drive1(input logic [W-1:0] a, input logic [W-1:0] b, input logic s0, input logic s1);
      in1A = a; in1B = b; in1S0 = s0; in1S1 = s1; req1 = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ack1) break;
      end
      req1 = 1'b0;
   endtask

   initial begin
      Reset = 1'b0;
      req0 = 1'b0; in0A = '0; in0B = '0; in0S0 = 1'b0; in0S1 = 1'b0;
      req1 = 1'b0; in1A = '0; in1B = '0; in1S0 = 1'b0; in1S1 = 1'b0;

      // Both requesters held from reset: alternating grants.
      fork
         begin repeat (3) @(negedge clk); Reset = 1'b1; end
         begin drive0(4'd6, 4'd11, 1'b0, 1'b1); drive0(4'd9, 4'd3, 1'b1, 1'b1); end
         begin drive1(4'd13, 4'd7, 1'b1, 1'b0); drive1(4'd1, 4'd15, 1'b0, 1'b0); end
      join

      drive0(4'd3, 4'd5, 1'b0, 1'b0);
      drive1(4'd15, 4'd15, 1'b1, 1'b0);
      drive1(4'd15, 4'd15, 1'b1, 1'b1);
      drive0(4'd0, 4'd9, 1'b0, 1'b1);
      drive0(4'd7, 4'd1, 1'b0, 1'b0);
      drive0(4'd2, 4'd5, 1'b0, 1'b1);
      drive1(4'd0, 4'd0, 1'b1, 1'b1);

      // Abort an operation in its second CALC cycle while req1 waits.
      drive0(4'd5, 4'd6, 1'b1, 1'b0);
      fork
         drive1(4'd9, 4'd9, 1'b0, 1'b0);
         begin @(negedge clk); Reset = 1'b0; @(negedge clk); Reset = 1'b1; end
      join

      fork
         for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive0(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         end
         for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive1(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         end
      join

      repeat (15) @(negedge clk);
      drain = 1'b1;
      for (int i = 0; i < 10 && !fin; i++) @(posedge clk);
      @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/signed_mul_scheduler.md
Name: signed_mul_scheduler

Overview:
- Sequential signed-magnitude multiplier engine shared between two requesters through a round-robin arbiter.
- Each requester supplies two WIDTH-bit magnitudes and two sign bits.
- The block grants one requester, runs a shift-add multiply over WIDTH cycles, then two's-complements the result when the signs differ.
- Returns a (2*WIDTH+1)-bit product tagged with the requester id. Sits between the operand sources and the result consumer.

Parameters:
- WIDTH, 4, operand magnitude width. Product width is 2*WIDTH+1.

Ports:
- clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 request; held until ack0.
- in0A  input  WIDTH  requester 0 multiplicand magnitude.
- in0B  input  WIDTH  requester 0 multiplier magnitude.
- in0S0  input  1  requester 0 sign of in0A.
- in0S1  input  1  requester 0 sign of in0B.
- ack0  output  1  one-cycle acceptance pulse to requester 0.
- req1, in1A, in1B, in1S0, in1S1, ack1: same as requester 0, for requester 1.
- Product  output  2*WIDTH+1  registered result, two's complement.
- result_valid  output  1  one-cycle pulse; Product is valid.
- result_id  output  1  requester that owns Product.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (Reset=0 at a clock edge):
  - state=IDLE; ack0=ack1=0; result_valid=0; Product=0; result_id=0; busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE -> CALC -> SIGN -> DONE -> IDLE.
- IDLE, at an edge E0 with any req high:
  - Grant req0 if only req0 is high, req1 if only req1 is high.
  - If both are high, grant the requester that is not last_grant.
  - Update last_grant.
  - Capture mcand=inXA, mplier=inXB, neg=inXS0^inXS1, id=X; clear acc and count.
  - Go to CALC.
  - ackX is registered: high for exactly the cycle after E0 (the first CALC cycle).
  - Requests are ignored in every state except IDLE.
- CALC, one iteration per edge (E1..EWIDTH):
  - If mplier[0]=1, add mcand shifted left by count into acc.
  - Shift mplier right by 1; increment count.
  - After the WIDTH-th iteration, go to SIGN.
  - acc is 2*WIDTH bits and cannot overflow (max (2^WIDTH-1)^2).
- SIGN, one edge:
  - Product = neg ? ({1'b0,acc} two's complement, 2*WIDTH+1 bits) : {1'b0,acc}.
  - result_id = id. Go to DONE.
- DONE: result_valid=1 for this single cycle; go to IDLE at the next edge.
- Latency:
  - result_valid rises at edge E0+WIDTH+1 (E0+5 for WIDTH=4).
  - The earliest next acceptance edge is E0+WIDTH+3, so throughput is one operation per WIDTH+3 cycles.
- Product holds its value between results; result_valid qualifies it.
- Zero magnitude with neg=1 gives Product=0 (no negative zero).
- WIDTH=4 extremes:
  - 15*15 with neg=0 gives 9'h0E1.
  - 15*15 with neg=1 gives 9'h11F.
- Reset mid-operation (any state):
  - Aborts the operation; no result_valid and no ack is emitted for it.
  - busy=0 from the cycle after the reset edge.
  - A requester whose ack has not yet been pulsed must keep req asserted.
- A requester dropping req before its ack is legal; it simply is not granted.

Optional Feature:
- Macro: SIGNED_MUL_EARLY_TERM_EN.
- Enabled:
  - In CALC, go to SIGN at the edge where the post-shift mplier is 0.
  - CALC length is k = max(1, index of highest set bit of B + 1).
  - result_valid rises at E0+k+1.
  - last_grant and all other rules are unchanged.
- Disabled: fixed WIDTH-iteration CALC, as above.

Decomposition:
- Package signed_mul_pkg holds:
  - state enum (IDLE, CALC, SIGN, DONE);
  - WIDTH default;
  - PROD_W = 2*WIDTH+1;
  - count width $clog2(WIDTH+1).
- One sub-module: mul_rr_arbiter, a 2-way round-robin arbiter with last_grant register and update enable.
- The datapath and FSM stay in the top module.

Test Plan:
- req0, A=3, B=5, S0=0, S1=0 -> ack0 high at cycle E0+1; result_valid at E0+5; Product=9'h00F; result_id=0.
- req1, A=15, B=15, S0=1, S1=0 -> Product=9'h11F; result_id=1. Repeat with S0=S1=1 -> Product=9'h0E1.
- req0 and req1 both held from reset -> grant order 0, 1, 0, 1. Accepted ops are 7 cycles apart; each ack pulses once per grant.
- A=0, B=9, S0=0, S1=1 -> Product=9'h000, result_valid at E0+5.
- Reset=0 during the 2nd CALC cycle -> no result_valid ever for that op; busy=0 next cycle. A held req1 is then accepted first (last_grant reset to 1).
- With SIGNED_MUL_EARLY_TERM_EN:
  - A=7, B=1 -> Product=9'h007 at E0+2.
  - A=2, B=5, S1=1 -> Product=9'h1F6 at E0+4.
  - Without the macro, both arrive at E0+5.
